// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: turns key press/release edges into per-voice
// allocations, stealing the oldest voice when the pool is full.
module voice_allocator #(
    parameter int unsigned NUM_KEYS   = 32,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_KEYS-1:0]         i_keys,
    input  logic                        i_enable,
    output logic [NUM_VOICES-1:0]       o_voice_valid,
    output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
    output logic [NUM_VOICES-1:0]       o_note_on,
    output logic [NUM_VOICES-1:0]       o_note_off,
    output logic                        o_steal,
    output logic                        o_busy
);

    localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VOICE_W-1:0] AGE_MAX = VOICE_W'(NUM_VOICES - 1);

    logic [NUM_KEYS-1:0]         key_prev;
    logic [NUM_KEYS-1:0]         press_pend;
    logic [NUM_KEYS-1:0]         rel_pend;
    logic [VOICE_W-1:0]          age [NUM_VOICES];

    logic [NUM_KEYS-1:0]         rise;
    logic [NUM_KEYS-1:0]         fall;
    logic [KEY_W-1:0]            rel_idx;
    logic [KEY_W-1:0]            press_idx;
    logic                        hold_hit;
    logic [VOICE_W-1:0]          hold_v;
    logic                        free_hit;
    logic [VOICE_W-1:0]          free_v;
    logic [VOICE_W-1:0]          old_v;
    logic [VOICE_W-1:0]          old_age;
    logic [VOICE_W-1:0]          pick_v;
    logic                        do_rel;
    logic                        do_press;
    logic [NUM_KEYS-1:0]         svc_rel;
    logic [NUM_KEYS-1:0]         svc_press;

    logic [NUM_KEYS-1:0]         press_nxt;
    logic [NUM_KEYS-1:0]         rel_nxt;
    logic [NUM_VOICES-1:0]       valid_nxt;
    logic [NUM_VOICES*KEY_W-1:0] key_nxt;
    logic [VOICE_W-1:0]          age_nxt [NUM_VOICES];
    logic [NUM_VOICES-1:0]       on_nxt;
    logic [NUM_VOICES-1:0]       off_nxt;
    logic                        steal_nxt;

    // Edge detection, event selection and voice choice.
    always_comb begin
        rise      = i_keys & ~key_prev;
        fall      = ~i_keys & key_prev;
        rel_idx   = '0;
        press_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (rel_pend[k])   rel_idx   = KEY_W'(k);
            if (press_pend[k]) press_idx = KEY_W'(k);
        end

        hold_hit = 1'b0;
        hold_v   = '0;
        free_hit = 1'b0;
        free_v   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (o_voice_valid[v] && (o_voice_key[v*KEY_W +: KEY_W] == rel_idx)) begin
                hold_hit = 1'b1;
                hold_v   = VOICE_W'(v);
            end
            if (!o_voice_valid[v]) begin
                free_hit = 1'b1;
                free_v   = VOICE_W'(v);
            end
        end

        // Strict compare keeps the lowest index on equal ages.
        old_v   = '0;
        old_age = age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v] > old_age) begin
                old_age = age[v];
                old_v   = VOICE_W'(v);
            end
        end

        pick_v    = free_hit ? free_v : old_v;
        do_rel    = i_enable && (|rel_pend);
        do_press  = i_enable && !(|rel_pend) && (|press_pend);
        svc_rel   = do_rel   ? (NUM_KEYS'(1) << rel_idx)   : '0;
        svc_press = do_press ? (NUM_KEYS'(1) << press_idx) : '0;
    end

    // Next pending state and voice pool update.
    always_comb begin
        press_nxt = (press_pend & ~svc_press & ~fall) | rise;
        rel_nxt   = (rel_pend & ~svc_rel) | (fall & ~(press_pend & ~svc_press));
        valid_nxt = o_voice_valid;
        key_nxt   = o_voice_key;
        age_nxt   = age;
        on_nxt    = '0;
        off_nxt   = '0;
        steal_nxt = 1'b0;

        if (!i_enable) begin
            press_nxt = '0;
            rel_nxt   = '0;
            valid_nxt = '0;
            for (int v = 0; v < NUM_VOICES; v++) age_nxt[v] = '0;
        end else if (do_rel && hold_hit) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VOICE_W'(v) == hold_v) begin
                    valid_nxt[v] = 1'b0;
                    off_nxt[v]   = 1'b1;
                    age_nxt[v]   = '0;
                end
            end
        end else if (do_press) begin
            steal_nxt = !free_hit;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VOICE_W'(v) == pick_v) begin
                    valid_nxt[v]                 = 1'b1;
                    key_nxt[v*KEY_W +: KEY_W]    = press_idx;
                    on_nxt[v]                    = 1'b1;
                    age_nxt[v]                   = '0;
                end else if (o_voice_valid[v] && (age[v] != AGE_MAX)) begin
                    age_nxt[v] = age[v] + VOICE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_prev      <= '0;
            press_pend    <= '0;
            rel_pend      <= '0;
            o_voice_valid <= '0;
            o_voice_key   <= '0;
            o_note_on     <= '0;
            o_note_off    <= '0;
            o_steal       <= 1'b0;
            o_busy        <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
        end else begin
            key_prev      <= i_keys;
            press_pend    <= press_nxt;
            rel_pend      <= rel_nxt;
            o_voice_valid <= valid_nxt;
            o_voice_key   <= key_nxt;
            o_note_on     <= on_nxt;
            o_note_off    <= off_nxt;
            o_steal       <= steal_nxt;
            o_busy        <= (|press_nxt) | (|rel_nxt);
            age           <= age_nxt;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator against an event-level reference model
// of the key queues and voice pool.
module tb_voice_allocator;

    localparam int NK = 32;
    localparam int NV = 4;
    localparam int KW = 5;

    logic             clk;
    logic             rst_n;
    logic [NK-1:0]    keys;
    logic             enable;
    logic [NV-1:0]    voice_valid;
    logic [NV*KW-1:0] voice_key;
    logic [NV-1:0]    note_on;
    logic [NV-1:0]    note_off;
    logic             steal;
    logic             busy;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_keys        (keys),
        .i_enable      (enable),
        .o_voice_valid (voice_valid),
        .o_voice_key   (voice_key),
        .o_note_on     (note_on),
        .o_note_off    (note_off),
        .o_steal       (steal),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit          m_prev  [NK];
    bit          m_press [NK];
    bit          m_rel   [NK];
    bit          m_valid [NV];
    int          m_key   [NV];
    int          m_age   [NV];
    logic [NV-1:0] e_on, e_off;
    logic          e_steal, e_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_prev[k] = 0; m_press[k] = 0; m_rel[k] = 0;
        end
        for (int v = 0; v < NV; v++) begin
            m_valid[v] = 0; m_key[v] = 0; m_age[v] = 0;
        end
        e_on = '0; e_off = '0; e_steal = 1'b0; e_busy = 1'b0;
    endfunction

    // One clock edge of the spec's rules, applied to the model.
    function automatic void model_step(input logic [NK-1:0] kv, input logic en);
        int  rk, pk, sel;
        bit  np, nr, r, f;
        bit  was_valid [NV];
        e_on = '0; e_off = '0; e_steal = 1'b0;
        rk = -1; pk = -1;
        if (en) begin
            for (int k = NK - 1; k >= 0; k--) begin
                if (m_rel[k])   rk = k;
                if (m_press[k]) pk = k;
            end
            if (rk >= 0) begin
                pk = -1;
                for (int v = 0; v < NV; v++)
                    if (m_valid[v] && m_key[v] == rk) begin
                        m_valid[v] = 0; m_age[v] = 0; e_off[v] = 1'b1;
                    end
            end else if (pk >= 0) begin
                sel = -1;
                for (int v = 0; v < NV; v++)
                    if (!m_valid[v] && sel < 0) sel = v;
                if (sel < 0) begin
                    e_steal = 1'b1;
                    sel = 0;
                    for (int v = 1; v < NV; v++)
                        if (m_age[v] > m_age[sel]) sel = v;
                end
                was_valid = m_valid;
                for (int v = 0; v < NV; v++)
                    if (v != sel && was_valid[v])
                        m_age[v] = (m_age[v] + 1 > NV - 1) ? NV - 1 : m_age[v] + 1;
                m_age[sel] = 0; m_valid[sel] = 1; m_key[sel] = pk; e_on[sel] = 1'b1;
            end
        end
        e_busy = 1'b0;
        for (int k = 0; k < NK; k++) begin
            r  = kv[k] && !m_prev[k];
            f  = !kv[k] && m_prev[k];
            np = m_press[k] && (k != pk);
            nr = m_rel[k] && (k != rk);
            if (r) np = 1;
            if (f) begin
                if (m_press[k] && k != pk) np = 0;
                else nr = 1;
            end
            if (!en) begin np = 0; nr = 0; end
            m_press[k] = np; m_rel[k] = nr; m_prev[k] = kv[k];
            if (np || nr) e_busy = 1'b1;
        end
        if (!en)
            for (int v = 0; v < NV; v++) begin m_valid[v] = 0; m_age[v] = 0; end
    endfunction

    task automatic check_all();
        logic [NV-1:0]    ev;
        logic [NV*KW-1:0] ek, mk;
        ek = '0; mk = '0;
        for (int v = 0; v < NV; v++) begin
            ev[v] = m_valid[v];
            ek[v*KW +: KW] = KW'(m_key[v]);
            mk[v*KW +: KW] = m_valid[v] ? {KW{1'b1}} : {KW{1'b0}};
        end
        chk("valid",    32'(voice_valid),     32'(ev));
        chk("key",      32'(voice_key & mk),  32'(ek & mk));
        chk("note_on",  32'(note_on),         32'(e_on));
        chk("note_off", 32'(note_off),        32'(e_off));
        chk("steal",    32'(steal),           32'(e_steal));
        chk("busy",     32'(busy),            32'(e_busy));
    endtask

    task automatic cycle(input logic [NK-1:0] kv, input logic en);
        keys   = kv;
        enable = en;
        model_step(kv, en);
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [NK-1:0] kv;
    int            busy_n;
    int            en_low;

    initial begin
        rst_n = 1'b0; keys = '0; enable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single press and release of key 7
        kv = '0;
        cycle(kv, 1'b1);
        kv[7] = 1'b1;
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
        chk("sp_on",  32'(note_on), 32'd1);
        chk("sp_key", 32'(voice_key[4:0]), 32'd7);
        kv[7] = 1'b0;
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
        chk("sp_off", 32'(note_off), 32'd1);

        // Simultaneous press of 3, 9, 20
        kv = '0; kv[3] = 1'b1; kv[9] = 1'b1; kv[20] = 1'b1;
        busy_n = 0;
        repeat (5) begin
            cycle(kv, 1'b1);
            busy_n += int'(busy);
        end
        chk("tri_busy", 32'(busy_n), 32'd3);
        chk("tri_keys", 32'(voice_key[14:0]), 32'({5'd20, 5'd9, 5'd3}));
        kv = '0;
        repeat (6) cycle(kv, 1'b1);

        // Fill the pool with 1..4, then steal with 5
        for (int i = 1; i <= 4; i++) begin
            kv[i] = 1'b1;
            repeat (2) cycle(kv, 1'b1);
        end
        kv[5] = 1'b1;
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
        chk("stl_flag", 32'(steal), 32'd1);
        chk("stl_on",   32'(note_on), 32'd1);
        chk("stl_key",  32'(voice_key[4:0]), 32'd5);
        kv[1] = 1'b0;
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
        chk("stl_rel_off", 32'(note_off), 32'd0);

        // Release beats press in the same cycle
        kv[2] = 1'b0; kv[6] = 1'b1;
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
        chk("pri_off", 32'(note_off), 32'b0010);
        cycle(kv, 1'b1);
        chk("pri_on",    32'(note_on), 32'b0010);
        chk("pri_steal", 32'(steal), 32'd0);

        // Disable frees everything; held keys stay silent afterwards
        cycle(kv, 1'b0);
        chk("dis_valid", 32'(voice_valid), 32'd0);
        chk("dis_busy",  32'(busy), 32'd0);
        repeat (3) cycle(kv, 1'b1);
        chk("reen_valid", 32'(voice_valid), 32'd0);
        kv = '0;
        repeat (4) cycle(kv, 1'b1);

        // Randomized traffic with occasional disable and one mid-run reset
        en_low = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, NK - 1))
                                                : int'($urandom_range(0, 11));
                kv[k] = ~kv[k];
            end
            if (en_low > 0) en_low--;
            else if ($urandom_range(0, 79) == 0) en_low = int'($urandom_range(1, 3));
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle(kv, (en_low == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
